nf10_axis_width_converter_v2: RTL

- Parametrised AXI4-Stream width converter for the NetFPGA-10G datapath. Supports upsizing, downsizing and equal-width pass-through, selected at elaboration by the data-width parameters.
- Sits between 64-bit MAC/DMA ports and the 256-bit core pipeline, in either direction.
- Propagates per-packet tuser metadata, with optional default source/destination port insertion, and keeps packet and malformed-beat statistics.

---
 rtl/nf10_axis_width_converter_v2.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/nf10_axis_width_converter_v2.sv
// AXI4-Stream up/down/equal width converter with tuser default-port fill and packet/error stats.
// Latency 1 cycle; s_axis_tready drops only while a finished word (or held slices) awaits m_axis_tready.
module nf10_axis_width_converter_v2 #(
  parameter int C_S_AXIS_DATA_WIDTH = 64,
  parameter int C_M_AXIS_DATA_WIDTH = 256,
  parameter int C_TUSER_WIDTH = 128,
  parameter int C_LEN_WIDTH = 16,
  parameter int C_SPT_WIDTH = 8,
  parameter int C_DPT_WIDTH = 8,
  parameter int C_DEFAULT_VALUE_ENABLE = 0,
  parameter logic [C_SPT_WIDTH-1:0] C_DEFAULT_SRC_PORT = 8'h00,
  parameter logic [C_DPT_WIDTH-1:0] C_DEFAULT_DST_PORT = 8'h00
) (
  input  logic                             axi_aclk,
  input  logic                             axi_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [C_TUSER_WIDTH-1:0]         s_axis_tuser,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic [C_TUSER_WIDTH-1:0]         m_axis_tuser,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic [31:0]                      stat_pkt_count,
  output logic [15:0]                      stat_err_count
);
  localparam int SW = C_S_AXIS_DATA_WIDTH;
  localparam int MW = C_M_AXIS_DATA_WIDTH;
  localparam int SB = SW / 8;
  localparam int MB = MW / 8;
  localparam int TU = C_TUSER_WIDTH;
  localparam int SPT_LO = C_LEN_WIDTH;
  localparam int DPT_LO = C_LEN_WIDTH + C_SPT_WIDTH;

  function automatic logic [TU-1:0] fix_user(input logic [TU-1:0] u);
    logic [TU-1:0] r;
    r = u;
    if (C_DEFAULT_VALUE_ENABLE != 0) begin
      if (u[SPT_LO +: C_SPT_WIDTH] == '0) r[SPT_LO +: C_SPT_WIDTH] = C_DEFAULT_SRC_PORT;
      if (u[DPT_LO +: C_DPT_WIDTH] == '0) r[DPT_LO +: C_DPT_WIDTH] = C_DEFAULT_DST_PORT;
    end
    return r;
  endfunction

  logic run;   // holds s_axis_tready low until the first clock after reset release
  logic sof;
  logic s_acc;
  logic m_hs;

  assign s_acc = s_axis_tvalid & s_axis_tready;
  assign m_hs  = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      run            <= 1'b0;
      sof            <= 1'b1;
      stat_pkt_count <= '0;
      stat_err_count <= '0;
    end else begin
      run <= 1'b1;
      if (s_acc) sof <= s_axis_tlast;
      if (m_hs && m_axis_tlast) stat_pkt_count <= stat_pkt_count + 32'd1;
      if (s_acc && s_axis_tlast && s_axis_tstrb == '0 && stat_err_count != 16'hFFFF)
        stat_err_count <= stat_err_count + 16'd1;
    end
  end

  generate
    if (SW <= MW) begin : g_up
      // Equal widths fall out of this path with a single slot: a plain register slice.
      localparam int R  = MW / SW;
      localparam int CW = (R > 1) ? $clog2(R) : 1;
      logic [CW-1:0] slot;
      logic [MW-1:0] dat_q;
      logic [MB-1:0] strb_q;
      logic [TU-1:0] user_q;
      logic          last_q;
      logic          vld_q;

      assign s_axis_tready = run & (~vld_q | m_axis_tready);

      always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
          slot   <= '0;
          dat_q  <= '0;
          strb_q <= '0;
          user_q <= '0;
          last_q <= 1'b0;
          vld_q  <= 1'b0;
        end else begin
          if (m_hs) vld_q <= 1'b0;
          if (s_acc) begin
            for (int i = 0; i < R; i++) begin
              if (slot == CW'(i)) begin
                dat_q[i*SW +: SW]  <= s_axis_tdata;
                strb_q[i*SB +: SB] <= s_axis_tstrb;
              end else if (slot == '0) begin
                dat_q[i*SW +: SW]  <= '0;
                strb_q[i*SB +: SB] <= '0;
              end
            end
            if (sof) user_q <= fix_user(s_axis_tuser);
            if (slot == CW'(R - 1) || s_axis_tlast) begin
              vld_q  <= 1'b1;
              last_q <= s_axis_tlast;
              slot   <= '0;
            end else begin
              slot <= slot + CW'(1);
            end
          end
        end
      end

      assign m_axis_tdata  = dat_q;
      assign m_axis_tstrb  = strb_q;
      assign m_axis_tuser  = user_q;
      assign m_axis_tlast  = last_q;
      assign m_axis_tvalid = vld_q;
    end else begin : g_down
      localparam int R  = SW / MW;
      localparam int CW = $clog2(R);
      logic [SW-1:0] hdat;
      logic [SB-1:0] hstrb;
      logic          hlast;
      logic          hvld;
      logic [CW-1:0] idx;
      logic [CW-1:0] lidx;
      logic [TU-1:0] user_q;
      logic          final_slice;

      // Last slice to emit: all of them mid-packet, else the highest one carrying bytes.
      function automatic logic [CW-1:0] last_slice(input logic [SB-1:0] st, input logic last);
        logic [CW-1:0] r;
        r = CW'(R - 1);
        if (last) begin
          r = '0;
          for (int i = 0; i < R; i++)
            if (st[i*MB +: MB] != '0) r = CW'(i);
        end
        return r;
      endfunction

      assign final_slice   = (idx == lidx);
      assign s_axis_tready = run & (~hvld | (m_axis_tready & final_slice));

      always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
          hdat   <= '0;
          hstrb  <= '0;
          hlast  <= 1'b0;
          hvld   <= 1'b0;
          idx    <= '0;
          lidx   <= '0;
          user_q <= '0;
        end else if (s_acc) begin
          hdat  <= s_axis_tdata;
          hstrb <= s_axis_tstrb;
          hlast <= s_axis_tlast;
          hvld  <= 1'b1;
          idx   <= '0;
          lidx  <= last_slice(s_axis_tstrb, s_axis_tlast);
          if (sof) user_q <= fix_user(s_axis_tuser);
        end else if (m_hs) begin
          if (final_slice) hvld <= 1'b0;
          else idx <= idx + CW'(1);
        end
      end

      always_comb begin
        m_axis_tdata = '0;
        m_axis_tstrb = '0;
        for (int i = 0; i < R; i++) begin
          if (idx == CW'(i)) begin
            m_axis_tdata = hdat[i*MW +: MW];
            m_axis_tstrb = hstrb[i*MB +: MB];
          end
        end
      end

      assign m_axis_tuser  = user_q;
      assign m_axis_tlast  = hvld & hlast & final_slice;
      assign m_axis_tvalid = hvld;
    end
  endgenerate
endmodule
